// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C channel arbiter: FSM state encoding,
// default watchdog width and a one-hot to index helper.
package i2c_arb_pkg;

    localparam int MAX_N    = 16;
    localparam int DEF_TO_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LAUNCH,
        ST_WAIT_LOW,
        ST_WAIT_HIGH
    } state_e;

    // Index of the set bit of a one-hot vector; 0 for an all-zero vector.
    function automatic logic [3:0] onehot_idx(input logic [MAX_N-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first requester at or above the
// pointer, wrapping modulo N, as a one-hot vector plus a valid flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic          valid_o
);

    always_comb begin
        logic [PW:0] idx;
        // NOTE: every output gets a default first, so no path leaves a latch.
        win_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_i} + (PW + 1)'(k);
            if (idx >= (PW + 1)'(N)) idx = idx - (PW + 1)'(N);
            if (!valid_o && req_i[idx[PW-1:0]]) begin
                win_o[idx[PW-1:0]] = 1'b1;
                valid_o            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_chan_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between N channels.
// Define I2C_ARB_TIMEOUT_EN to add the TO_W-bit transaction watchdog.
module i2c_chan_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int TO_W = DEF_TO_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_bus,
    input  logic         eng_ready,
    output logic [N-1:0] grant_bus,
    output logic         eng_start,
    output logic [N-1:0] done_bus,
    output logic [N-1:0] err_bus,
    output logic         eng_abort,
    output logic         busy
);

    localparam int PW = $clog2(N);

    if (N < 2 || N > MAX_N || TO_W < 2) begin : g_bad_cfg
        $error("i2c_chan_arbiter: unsupported N or TO_W");
    end

    state_e        state_q;
    logic [N-1:0]  grant_q;
    logic [N-1:0]  done_q;
    logic          start_q;
    logic          busy_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  win;
    logic          win_valid;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [TO_W-1:0] wdog_q;
    logic [N-1:0]    err_q;
    logic            abort_q;
    logic            wd_expired;

    assign wd_expired = &wdog_q;
`endif

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req_i   (req_bus),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

    // The channel that just finished drops to lowest priority.
    always_comb begin
        logic [3:0] gidx;
        gidx  = onehot_idx(MAX_N'(grant_q));
        ptr_d = (gidx == 4'(N - 1)) ? '0 : PW'(gidx + 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments only, so every register sees pre-edge values.
            start_q <= 1'b0;
            done_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q   <= '0;
            abort_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        grant_q <= win;
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    start_q <= 1'b1;
                    state_q <= ST_LAUNCH;
`ifdef I2C_ARB_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    if (wd_expired) begin
                        err_q   <= grant_q;
                        abort_q <= 1'b1;
                        ptr_q   <= ptr_d;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                        if (!eng_ready) state_q <= ST_WAIT_HIGH;
                    end
`else
                    if (!eng_ready) state_q <= ST_WAIT_HIGH;
`endif
                end
                ST_WAIT_HIGH: begin
                    if (eng_ready) begin
                        done_q  <= grant_q;
                        ptr_q   <= ptr_d;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (wd_expired) begin
                        err_q   <= grant_q;
                        abort_q <= 1'b1;
                        ptr_q   <= ptr_d;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_bus = grant_q;
    assign eng_start = start_q;
    assign done_bus  = done_q;
    assign busy      = busy_q;

`ifdef I2C_ARB_TIMEOUT_EN
    assign err_bus   = err_q;
    assign eng_abort = abort_q;
`else
    assign err_bus   = '0;
    assign eng_abort = 1'b0;
`endif

endmodule

// File: doc/i2c_chan_arbiter.md
# i2c_chan_arbiter

Round-robin controller that shares the single I2C master engine between N channel requesters. Each requester raises a request when it holds a complete transaction. The arbiter grants one channel at a time with a one-hot select, pulses the engine start, and tracks the engine `ready` handshake to completion. It then reports done per channel and rotates priority. It sits between the per-channel command queues and the engine/pin mux, and drives the one-hot select that the pin mux and slave-message demux consume.

## Interface
- `N`, default 4: number of channels, 2..16.
- `TO_W`, default 20: transaction watchdog counter width in clk cycles (used only with the timeout feature).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_bus`  in  N  per-channel "transaction pending" level.
- `eng_ready`  in  1  engine idle flag (1 = idle).
- `grant_bus`  out  N  one-hot channel select; all zero when idle.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `done_bus`  out  N  one-cycle pulse on the granted bit when its transaction completes.
- `err_bus`  out  N  one-cycle pulse on the granted bit when its transaction is aborted by the watchdog.
- `eng_abort`  out  1  one-cycle engine reset pulse on watchdog abort.
- `busy`  out  1  high whenever `grant_bus` is non-zero.

## Operation
- Reset values: `grant_bus`=0, `eng_start`=0, `done_bus`=0, `err_bus`=0, `eng_abort`=0, `busy`=0, state=IDLE, priority pointer=0, watchdog=0.
- States: IDLE, GRANT, LAUNCH, WAIT_LOW, WAIT_HIGH.
- **IDLE**
  - If `req_bus`≠0, pick the first set bit searching upward from the pointer, wrapping modulo N.
  - Register the winner into `grant_bus` and go to GRANT.
- **GRANT**: `eng_start`<=1, go to LAUNCH. This gives one cycle for the pin mux to settle before start.
- **LAUNCH**: `eng_start`<=0, go to WAIT_LOW.
- **WAIT_LOW**: wait for `eng_ready`=0, meaning the engine accepted the start, then go to WAIT_HIGH.
- **WAIT_HIGH**: on `eng_ready`=1:
  - pulse `done_bus` on the granted bit;
  - set the pointer to winner index+1, wrapping to 0 after N-1;
  - clear `grant_bus` and return to IDLE.
- Grant is held for the whole transaction. Deasserting `req_bus` mid-transaction has no effect.
- Requests arriving during a transaction are serviced after it. There is always at least one IDLE cycle between consecutive grants.
- A channel that re-requests immediately after completing has lowest priority in the next arbitration.
- `grant_bus` never has more than one bit set.

## Timing
- `req_bus` to `grant_bus`: 1 cycle.
- `grant_bus` to `eng_start`: 1 cycle.
- `eng_start` is high for exactly 1 cycle.
- `done_bus` pulse is registered in the same edge that clears `grant_bus`.
- Minimum request-to-done time is 5 cycles plus the engine busy time.
- `rst` asserted mid-transaction returns everything to reset values on the next edge. No done or err pulse is emitted.

## Configuration
- Macro `I2C_ARB_TIMEOUT_EN`.
- **Defined**:
  - A TO_W-bit watchdog clears on entry to LAUNCH and increments in WAIT_LOW and WAIT_HIGH.
  - When it reaches all ones: pulse `eng_abort` and the granted `err_bus` bit for 1 cycle, advance the pointer as on done, clear the grant, and go to IDLE.
  - Done takes precedence if `eng_ready` rises in the same cycle the watchdog expires.
- **Undefined**: no watchdog; `err_bus` and `eng_abort` are tied to 0, and the arbiter waits indefinitely.

## Structure
- Shared package `i2c_arb_pkg`: state enum (IDLE..WAIT_HIGH), the default `TO_W`, and a function returning the index of a one-hot vector.
- One sub-module, `rr_pick`: combinational rotate-priority encoder with inputs request vector and pointer, outputs one-hot winner and valid.

## Test plan
- N=4, reset, `req_bus`=4'b0100, engine model drops ready 2 cycles after start and raises it 30 cycles later:
  - `grant_bus`=0100 one cycle after the request;
  - `eng_start` one cycle later;
  - `done_bus`=0100 pulses once;
  - next grant search starts from channel 3.
- `req_bus`=4'b1111 held continuously: grants occur in order 0001, 0010, 0100, 1000, 0001, each separated by at least one IDLE cycle.
- `req_bus` for channel 1 drops in WAIT_HIGH: grant is still held until ready rises, then `done_bus`=0010 pulses.
- With `I2C_ARB_TIMEOUT_EN` and `TO_W`=6, engine never raises ready: after 63 wait cycles `eng_abort` and `err_bus`=granted bit pulse once, then the grant clears.
- `rst` asserted during WAIT_LOW: on the next edge all outputs are 0, and the following request on channel 2 yields `grant_bus`=0100 with the pointer at 0.
- Without the macro, engine stuck busy for 10^6 cycles: no `err_bus` pulse, and the grant is held.
